serial_bit_source: RTL and testbench
====================================

# serial_bit_source

Parallel-to-serial stage that drives the `q` input of the sequence-detector FSM. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word ahead. It shifts each word out one bit per clock on `q`, inserting an optional idle gap between words. `q` updates on the rising edge of `clk`, so the detector's falling-edge sample always sees a value that has been stable for half a cycle.

## Interface
- WIDTH, 8, word length in bits; legal range 2..16.
- GAP, 0, idle cycles inserted after each word; legal range 0..15.
- IDLE_LEVEL, 0, value of `q` when no bit is being sent.
- clk  input  1  single clock; all state updates on rising edge.
- init  input  1  reset; one clock, reset is synchronous and active-low.
- din  input  WIDTH  word to serialize.
- din_valid  input  1  `din` is valid.
- din_ready  output  1  block can accept a word; transfer occurs on a rising edge where valid and ready are both 1.
- msb_first  input  1  bit order, sampled with the word at accept: 1 = MSB first, 0 = LSB first.
- q  output  1  serial bit to the detector; registered.
- busy  output  1  high whenever state is not IDLE.
- bit_idx  output  clog2(WIDTH)  index (0-based, in send order) of the bit currently on `q`; 0 when not shifting.
- word_done  output  1  high during the cycle the last bit of a word is on `q`.

## Operation
- Storage: one hold buffer (`hbuf`, `hdir`, `hfull`), one shift register `sreg`, latched order `dir`, and counters `cnt` (bit) and `gcnt` (gap).
- `din_ready` = `~hfull & init` (combinational). Accept: `hbuf`<=`din`, `hdir`<=`msb_first`, `hfull`<=1.
- States: IDLE, SHIFT, GAP.
- IDLE: `q`=IDLE_LEVEL. If `hfull`: load `sreg`<=`hbuf`, `dir`<=`hdir`, drive the first bit onto `q`, set `cnt`=0, clear `hfull` unless an accept happens on the same edge, then go to SHIFT.
- SHIFT: `q` = bit `cnt` in send order. On each edge with `cnt`<WIDTH-1, `cnt`++. On the edge ending the last bit:
  - GAP>0: go to GAP, `gcnt`=0, `q`=IDLE_LEVEL.
  - GAP=0 and `hfull`: load the next word immediately; `q` carries bit 0 of the new word; stay in SHIFT. The stream is continuous.
  - Otherwise: go to IDLE.
- GAP: `q`=IDLE_LEVEL. After GAP cycles, load from `hfull` (IDLE-style, directly into SHIFT) if a word is buffered, else go to IDLE.
- Simultaneous load from `hbuf` and accept into `hbuf` on one edge: the old word goes to `sreg` and the new word goes to `hbuf`; `hfull` stays 1.
- `msb_first` changes after accept do not affect a buffered or in-flight word.
- `word_done` = (state==SHIFT & `cnt`==WIDTH-1), registered with `q`.
- Reset (`init`=0 at a rising edge), including mid-word or mid-gap: state=IDLE, `hfull`=0, `sreg`=0, `cnt`=`gcnt`=0, `q`=IDLE_LEVEL, `busy`=0, `bit_idx`=0, `word_done`=0. The in-flight word and the buffered word are discarded. `din_ready`=0 while `init`=0.

## Timing
- Accept at edge k → first bit on `q` after edge k+1. Latency is 2 cycles from valid&ready to the first bit on `q`.
- Each bit is held exactly one clock. A word occupies WIDTH cycles plus GAP idle cycles.
- Back-to-back throughput, GAP=0: one bit per clock with no bubble, provided the next word is accepted before the current word's last-bit edge.
- `din_ready` returns high on the edge that moves `hbuf` into `sreg`.
- All outputs except `din_ready` are registered and change only on the rising edge of `clk`.

## Test plan
- Reset then idle: hold `init`=0 for 2 cycles, release, hold `din_valid`=0 → `q`=0, `busy`=0, `din_ready`=1, `word_done`=0 throughout.
- Single word, WIDTH=8, GAP=0: send `din`=8'hB4 with `msb_first`=1 → starting 2 cycles after accept, `q`=1,0,1,1,0,1,0,0; `word_done` high in the 8th bit cycle only; then `busy`=0 and `q`=0.
- LSB first: send 8'hB4 with `msb_first`=0 → `q`=0,0,1,0,1,1,0,1.
- Back-to-back, GAP=0: send 8'h3C then 8'hFF with `din_valid` held high → 16 consecutive bit cycles with no idle, `q`=0,0,1,1,1,1,0,0,1,1,1,1,1,1,1,1. `din_ready` drops after the second accept and rises when 8'hFF loads.
- Gap insertion, GAP=3: send two words 8'h81 back-to-back → `q`=1,0,0,0,0,0,0,1, then 0,0,0 (3 gap cycles), then 1,0,0,0,0,0,0,1.
- Reset mid-word: send 8'hFF, assert `init`=0 during bit 4 → on the next edge `q`=0, `busy`=0, `bit_idx`=0. After release, no further bits from 8'hFF appear, and a new word 8'hA5 serializes cleanly as 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/serial_bit_source_if.sv
// rtl/serial_bit_source_if.sv - word handshake into the parallel-to-serial stage
interface serial_bit_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             msb_first;

  modport master (output din, din_valid, msb_first, input din_ready);
  modport slave  (input din, din_valid, msb_first, output din_ready);
endinterface

// File: rtl/serial_bit_source.sv
// rtl/serial_bit_source.sv - parallel-to-serial source with one-word hold buffer and idle gap
// Feeds the sequence detector; q changes only on the rising edge of clk.
module serial_bit_source #(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     init,
  serial_bit_source_if.slave       bus,
  output logic                     q,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     word_done
);
  localparam int              IW    = $clog2(WIDTH);
  localparam logic [IW-1:0]   LAST  = IW'(WIDTH - 1);
  localparam logic [3:0]      GLAST = 4'(GAP - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hbuf_q, hbuf_d;
  logic              hdir_q, hdir_d;
  logic              hfull_q, hfull_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic              dir_q, dir_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic              q_q, q_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic              word_done_q, word_done_d;
  logic              accept, load, shifting;
  logic [IW-1:0]     sel;

  assign bus.din_ready = ~hfull_q & init;
  assign q             = q_q;
  assign busy          = (state_q != ST_IDLE);
  assign bit_idx       = bit_idx_q;
  assign word_done     = word_done_q;

  always_comb begin
    accept  = bus.din_valid & bus.din_ready;
    load    = 1'b0;
    state_d = state_q;
    hbuf_d  = hbuf_q;
    hdir_d  = hdir_q;
    hfull_d = hfull_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_IDLE: load = hfull_q;
      ST_SHIFT: begin
        if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
        else if (GAP > 0) begin
          state_d = ST_GAP;
          gcnt_d  = '0;
        end else if (hfull_q) load = 1'b1;
        else state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (gcnt_q != GLAST) gcnt_d = gcnt_q + 1'b1;
        else if (hfull_q) load = 1'b1;
        else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Load before accept so a same-edge accept leaves the new word buffered.
    if (load) begin
      state_d = ST_SHIFT;
      sreg_d  = hbuf_q;
      dir_d   = hdir_q;
      cnt_d   = '0;
      hfull_d = 1'b0;
    end
    if (accept) begin
      hbuf_d  = bus.din;
      hdir_d  = bus.msb_first;
      hfull_d = 1'b1;
    end
    shifting    = (state_d == ST_SHIFT);
    sel         = dir_d ? (LAST - cnt_d) : cnt_d;
    q_d         = shifting ? sreg_d[sel] : IDLE_LEVEL;
    bit_idx_d   = shifting ? cnt_d : '0;
    word_done_d = shifting && (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      state_q     <= ST_IDLE;
      hbuf_q      <= '0;
      hdir_q      <= 1'b0;
      hfull_q     <= 1'b0;
      sreg_q      <= '0;
      dir_q       <= 1'b0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      q_q         <= IDLE_LEVEL;
      bit_idx_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hbuf_q      <= hbuf_d;
      hdir_q      <= hdir_d;
      hfull_q     <= hfull_d;
      sreg_q      <= sreg_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      q_q         <= q_d;
      bit_idx_q   <= bit_idx_d;
      word_done_q <= word_done_d;
    end
  end
endmodule

// File: tb/tb_serial_bit_source.sv
// tb/tb_serial_bit_source.sv - two instances (GAP=0, GAP=3) against a bit-schedule reference model
module tb_serial_bit_source;
  localparam int W    = 8;
  localparam int IW   = $clog2(W);
  localparam int GAP1 = 3;

  typedef struct packed {
    logic          q;
    logic          busy;
    logic [IW-1:0] idx;
    logic          done;
  } ent_t;
  localparam ent_t IDLE_E = '0;

  logic clk = 1'b0;
  logic init = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]  din_s[2];
  logic          valid_s[2];
  logic          msb_s[2];
  logic          rdy_o[2];
  logic          q_o[2];
  logic          busy_o[2];
  logic [IW-1:0] idx_o[2];
  logic          done_o[2];

  serial_bit_source_if #(.WIDTH(W)) bus0 ();
  serial_bit_source_if #(.WIDTH(W)) bus1 ();
  assign bus0.din = din_s[0];
  assign bus0.din_valid = valid_s[0];
  assign bus0.msb_first = msb_s[0];
  assign bus1.din = din_s[1];
  assign bus1.din_valid = valid_s[1];
  assign bus1.msb_first = msb_s[1];
  assign rdy_o[0] = bus0.din_ready;
  assign rdy_o[1] = bus1.din_ready;

  serial_bit_source #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .init(init), .bus(bus0.slave),
    .q(q_o[0]), .busy(busy_o[0]), .bit_idx(idx_o[0]), .word_done(done_o[0]));
  serial_bit_source #(.WIDTH(W), .GAP(GAP1), .IDLE_LEVEL(1'b0)) u_dut1 (
    .clk(clk), .init(init), .bus(bus1.slave),
    .q(q_o[1]), .busy(busy_o[1]), .bit_idx(idx_o[1]), .word_done(done_o[1]));

  // Reference: a queue of future per-cycle outputs, refilled from the held word.
  ent_t         sched[2][32];
  int           qlen[2];
  ent_t         cur[2];
  logic         hfull_m[2];
  logic [W-1:0] hbuf_m[2];
  logic         hdir_m[2];
  logic         acc_m[2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    ent_t e;
    logic rdy;
    for (int i = 0; i < 2; i++) begin
      acc_m[i] = 1'b0;
      if (!init) begin
        qlen[i] = 0;
        hfull_m[i] = 1'b0;
        cur[i] = IDLE_E;
      end else begin
        rdy = !hfull_m[i];
        if (qlen[i] == 0 && hfull_m[i]) begin
          for (int b = 0; b < W; b++) begin
            e.q    = hdir_m[i] ? hbuf_m[i][W-1-b] : hbuf_m[i][b];
            e.busy = 1'b1;
            e.idx  = IW'(b);
            e.done = (b == W - 1);
            sched[i][qlen[i]] = e;
            qlen[i]++;
          end
          for (int g = 0; g < (i == 0 ? 0 : GAP1); g++) begin
            e = IDLE_E;
            e.busy = 1'b1;
            sched[i][qlen[i]] = e;
            qlen[i]++;
          end
          hfull_m[i] = 1'b0;
        end
        if (qlen[i] > 0) begin
          cur[i] = sched[i][0];
          for (int k = 1; k < qlen[i]; k++) sched[i][k-1] = sched[i][k];
          qlen[i]--;
        end else begin
          cur[i] = IDLE_E;
        end
        if (rdy && valid_s[i]) begin
          hbuf_m[i]  = din_s[i];
          hdir_m[i]  = msb_s[i];
          hfull_m[i] = 1'b1;
          acc_m[i]   = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    ent_t o;
    #1;
    for (int i = 0; i < 2; i++)
      check_eq($sformatf("din_ready%0d", i), int'(rdy_o[i]), int'(!hfull_m[i] && init));
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      o = {q_o[i], busy_o[i], idx_o[i], done_o[i]};
      check_eq($sformatf("outs%0d{q,busy,idx,done}", i), int'(o), int'(cur[i]));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic push(input int i, input logic [W-1:0] w, input logic m);
    logic got;
    got = 1'b0;
    valid_s[i] = 1'b1;
    din_s[i]   = w;
    msb_s[i]   = m;
    for (int n = 0; n < 40 && !got; n++) begin
      cycle();
      got = acc_m[i];
    end
    if (!got) check_eq("push_timeout", 0, 1);
    valid_s[i] = 1'b0;
  endtask

  task automatic capture0(output logic [W-1:0] cap);
    int bits;
    bits = 0;
    cap  = '0;
    for (int n = 0; n < 30 && bits < W; n++) begin
      cycle();
      if (busy_o[0]) begin
        cap = {cap[W-2:0], q_o[0]};
        bits++;
      end
    end
  endtask

  logic [W-1:0] cap;
  logic         hit;

  initial begin
    for (int i = 0; i < 2; i++) begin
      valid_s[i] = 1'b0;
      din_s[i]   = '0;
      msb_s[i]   = 1'b0;
      qlen[i]    = 0;
      hfull_m[i] = 1'b0;
      hbuf_m[i]  = '0;
      hdir_m[i]  = 1'b0;
      cur[i]     = IDLE_E;
      acc_m[i]   = 1'b0;
    end
    @(posedge clk);
    #1;
    init = 1'b0;
    idle_cycles(2);
    init = 1'b1;
    idle_cycles(6);

    push(0, 8'hB4, 1'b1);
    capture0(cap);
    check_eq("b4_msb_first", int'(cap), 8'hB4);
    idle_cycles(3);
    push(0, 8'hB4, 1'b0);
    capture0(cap);
    check_eq("b4_lsb_first", int'(cap), 8'h2D);
    idle_cycles(3);

    push(0, 8'h3C, 1'b1);
    push(0, 8'hFF, 1'b1);
    idle_cycles(20);

    push(1, 8'h81, 1'b1);
    push(1, 8'h81, 1'b1);
    idle_cycles(25);

    push(0, 8'hFF, 1'b1);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      cycle();
      hit = cur[0].busy && (cur[0].idx == IW'(4));
    end
    if (!hit) check_eq("reach_bit4_timeout", 0, 1);
    init = 1'b0;
    cycle();
    init = 1'b1;
    idle_cycles(5);
    push(0, 8'hA5, 1'b1);
    capture0(cap);
    check_eq("a5_after_reset", int'(cap), 8'hA5);
    idle_cycles(4);

    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        valid_s[i] = ($urandom_range(0, 3) != 0);
        din_s[i]   = W'($urandom);
        msb_s[i]   = 1'($urandom_range(0, 1));
      end
      init = ($urandom_range(0, 99) != 0);
      cycle();
    end
    init = 1'b1;
    valid_s[0] = 1'b0;
    valid_s[1] = 1'b0;
    idle_cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
